// File: rtl/screen_arbiter_pkg.sv
// Shared Hack memory-map constants, arbiter state/access encodings and the CPU address decode
// used by the screen arbiter and the CPU memory decode.
package screen_arbiter_pkg;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] SCREEN_END  = 15'h5FFF;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

  // RD/WR touch the screen RAM; VAL returns a locally held word; DROP completes with no effect.
  typedef enum logic [1:0] {
    ACC_RD   = 2'd0,
    ACC_WR   = 2'd1,
    ACC_VAL  = 2'd2,
    ACC_DROP = 2'd3
  } acc_kind_e;

  typedef enum logic [1:0] {
    REG_SCREEN = 2'd0,
    REG_KBD    = 2'd1,
    REG_NONE   = 2'd2
  } region_e;

  function automatic region_e decode_region(input logic [14:0] addr);
    if (addr >= SCREEN_BASE && addr <= SCREEN_END) begin
      return REG_SCREEN;
    end else if (addr == KBD_ADDR) begin
      return REG_KBD;
    end
    return REG_NONE;
  endfunction

endpackage

// File: rtl/arb_starve_pick.sv
// Two-way winner select (video preferred) with a saturating CPU wait counter that forces the CPU
// ahead once it has waited CPU_MAX_WAIT cycles; grants are combinational, the counter is registered.
module arb_starve_pick #(
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic cpu_req,
  input  logic cpu_ack,
  input  logic vid_req,
  input  logic vid_ack,
  output logic grant_cpu,
  output logic grant_vid
);

  localparam int CNT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CPU_MAX_WAIT);

  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_d;
  logic             cpu_live;
  logic             vid_live;
  logic             starved;

  // A requester still showing its ack is holding a request that was just served.
  assign cpu_live = cpu_req & ~cpu_ack;
  assign vid_live = vid_req & ~vid_ack;
  assign starved  = (wait_q == MAX_CNT);

  always_comb begin
    grant_cpu = arb_en & cpu_live & (~vid_live | starved);
    grant_vid = arb_en & vid_live & ~grant_cpu;
  end

  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || grant_cpu) begin
      wait_d = '0;
    end else if (!cpu_ack && !starved) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/screen_arbiter.sv
// Shares the single-port 8K x 16 screen RAM between the Hack CPU and VGA scanout, and answers keyboard reads.
// Screen read acks 3 edges after grant, all other accesses 2; requesters hold req until their ack.
module screen_arbiter
  import screen_arbiter_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 8,
  parameter int KBD_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [14:0]      cpu_addr,
  input  logic [15:0]      cpu_wdata,
  output logic             cpu_ack,
  output logic [15:0]      cpu_rdata,
  input  logic             vid_req,
  input  logic [12:0]      vid_addr,
  output logic             vid_ack,
  output logic [15:0]      vid_rdata,
  input  logic [KBD_W-1:0] keyboard,
  output logic [12:0]      ram_addr,
  output logic [15:0]      ram_d,
  output logic             ram_we,
  input  logic [15:0]      ram_q
);

  arb_state_e  state_q;
  acc_kind_e   kind_q;
  logic        owner_vid_q;
  logic [15:0] val_q;
  logic [15:0] cpu_rdata_q;
  logic [15:0] vid_rdata_q;
  logic [12:0] ram_addr_q;
  logic [15:0] ram_d_q;
  logic        ram_we_q;
  logic        cpu_ack_q;
  logic        vid_ack_q;
  logic        arb_en;
  logic        grant_cpu;
  logic        grant_vid;

  // DONE doubles as an arbitration slot so back-to-back accesses need no idle bubble.
  assign arb_en = (state_q == ST_IDLE) || (state_q == ST_DONE);

  arb_starve_pick #(
    .CPU_MAX_WAIT(CPU_MAX_WAIT)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (arb_en),
    .cpu_req  (cpu_req),
    .cpu_ack  (cpu_ack_q),
    .vid_req  (vid_req),
    .vid_ack  (vid_ack_q),
    .grant_cpu(grant_cpu),
    .grant_vid(grant_vid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= ACC_RD;
      owner_vid_q <= 1'b0;
      val_q       <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_d_q     <= '0;
      ram_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      vid_ack_q <= 1'b0;
      ram_we_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (grant_cpu) begin
            owner_vid_q <= 1'b0;
            state_q     <= ST_ISSUE;
            case (decode_region(cpu_addr))
              REG_SCREEN: begin
                ram_addr_q <= cpu_addr[12:0];
                if (cpu_we) begin
                  ram_d_q  <= cpu_wdata;
                  ram_we_q <= 1'b1;
                  kind_q   <= ACC_WR;
                end else begin
                  kind_q   <= ACC_RD;
                end
              end
              REG_KBD: begin
                kind_q <= cpu_we ? ACC_DROP : ACC_VAL;
                val_q  <= 16'(keyboard);
              end
              default: begin
                kind_q <= cpu_we ? ACC_DROP : ACC_VAL;
                val_q  <= '0;
              end
            endcase
          end else if (grant_vid) begin
            owner_vid_q <= 1'b1;
            ram_addr_q  <= vid_addr;
            kind_q      <= ACC_RD;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (kind_q == ACC_RD) begin
            state_q <= ST_CAPTURE;
          end else begin
            // Writes commit in the RAM on this edge; non-RAM accesses only need the ack.
            state_q   <= ST_DONE;
            cpu_ack_q <= 1'b1;
            if (kind_q == ACC_VAL) begin
              cpu_rdata_q <= val_q;
            end
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_DONE;
          if (owner_vid_q) begin
            vid_rdata_q <= ram_q;
            vid_ack_q   <= 1'b1;
          end else begin
            cpu_rdata_q <= ram_q;
            cpu_ack_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign vid_rdata = vid_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_d     = ram_d_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_screen_arbiter.sv
// Bench for screen_arbiter: directed scenarios then random traffic, every cycle compared with a
// countdown/transaction reference model and a shadow copy of the screen RAM.
module tb_screen_arbiter;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ack, vid_req, vid_ack, ram_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata, vid_rdata, ram_d, ram_q;
  logic [12:0] vid_addr, ram_addr;
  logic [7:0]  keyboard;

  int n_checks = 0;
  int n_pass   = 0;
  int we_seen  = 0;

  always #5 clk = ~clk;

  screen_arbiter #(.CPU_MAX_WAIT(MAXW), .KBD_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .keyboard(keyboard),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37) ^ 16'hA5C3;
  endfunction

  // Screen RAM: synchronous, one-cycle read latency, read-before-write.
  logic [15:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      ram_q <= mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_d;
    end
  end

  // Reference model: an in-flight access is a countdown of edges to completion.
  int          m_left, m_op, m_addr, m_waddr, m_wait;
  bit          m_vid_own, m_ackc, m_ackv, m_we;
  logic [15:0] m_wd, m_val, m_cpu_rd, m_vid_rd;
  logic [15:0] smem [0:8191];

  task automatic model_reset();
    m_left = 0; m_wait = 0; m_ackc = 0; m_ackv = 0; m_we = 0;
    m_cpu_rd = '0; m_vid_rd = '0;
  endtask

  task automatic model_complete();
    case (m_op)
      0: if (m_vid_own) m_vid_rd = smem[m_addr]; else m_cpu_rd = smem[m_addr];
      1: smem[m_addr] = m_wd;
      2: m_cpu_rd = m_val;
      default: ;
    endcase
    if (m_vid_own) m_ackv = 1; else m_ackc = 1;
  endtask

  task automatic model_step();
    bit ce, ve, gc, gv, free;
    int a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a    = int'(cpu_addr);
    free = (m_left == 0);
    ce   = cpu_req && !m_ackc;
    ve   = vid_req && !m_ackv;
    gc   = free && ce && (!ve || m_wait == MAXW);
    gv   = free && ve && !gc;
    if (!cpu_req || gc) m_wait = 0;
    else if (!m_ackc && m_wait < MAXW) m_wait++;
    m_ackc = 0; m_ackv = 0; m_we = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) model_complete();
    end
    if (gc) begin
      m_vid_own = 0;
      if (a >= 'h4000 && a <= 'h5FFF) begin
        m_addr = a - 'h4000;
        if (cpu_we) begin
          m_op = 1; m_left = 1; m_we = 1; m_waddr = m_addr; m_wd = cpu_wdata;
        end else begin
          m_op = 0; m_left = 2;
        end
      end else begin
        m_left = 1;
        m_op   = cpu_we ? 3 : 2;
        m_val  = (a == 'h6000) ? 16'(keyboard) : 16'h0;
      end
    end else if (gv) begin
      m_vid_own = 1; m_op = 0; m_left = 2; m_addr = int'(vid_addr);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cpu_ack", 32'(cpu_ack), 32'(m_ackc));
    check("vid_ack", 32'(vid_ack), 32'(m_ackv));
    check("ram_we", 32'(ram_we), 32'(m_we));
    check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    check("vid_rdata", 32'(vid_rdata), 32'(m_vid_rd));
    if (m_we) begin
      check("ram_addr", 32'(ram_addr), 32'(m_waddr));
      check("ram_d", 32'(ram_d), 32'(m_wd));
    end
    we_seen += int'(ram_we);
  endtask

  task automatic cpu_txn(input logic [14:0] a, input logic we, input logic [15:0] wd, output int lat);
    cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1; lat = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      lat++;
      if (cpu_ack) break;
    end
    check("txn_ack_seen", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    cycle();
  endtask

  function automatic logic [14:0] pick_cpu_addr();
    logic [14:0] odd [0:3];
    odd[0] = 15'h3FFF; odd[1] = 15'h6001; odd[2] = 15'h7000; odd[3] = 15'h0000;
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 15'h4000 + 15'($urandom_range(0, 15));
      4:          return 15'h5FFF;
      5:          return 15'h6000;
      6:          return odd[$urandom_range(0, 3)];
      default:    return 15'($urandom);
    endcase
  endfunction

  initial begin
    int lat, gap, w0;
    for (int i = 0; i < 8192; i++) smem[i] = init_val(i);
    model_reset();

    // 1: reset with both requesters active, then video wins the first grant
    rst_n = 1'b0; keyboard = 8'h41;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h4001; cpu_wdata = '0;
    vid_req = 1'b1; vid_addr = 13'd7;
    cycle(); cycle();
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_d", 32'(ram_d), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (cpu_ack || vid_ack) break;
    end
    check("first_grant_vid", 32'({cpu_ack, vid_ack}), 32'b01);
    vid_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (cpu_ack) break;
    end
    check("first_cpu_rd", 32'(cpu_rdata), 32'(init_val(1)));
    cpu_req = 1'b0;
    cycle(); cycle();

    // 2: screen write then read back
    w0 = we_seen;
    cpu_txn(15'h4005, 1'b1, 16'hBEEF, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_pulses", 32'(we_seen - w0), 32'd1);
    cpu_txn(15'h4005, 1'b0, 16'h0, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", 32'(cpu_rdata), 32'hBEEF);

    // 3: keyboard read and dropped keyboard write
    w0 = we_seen;
    cpu_txn(15'h6000, 1'b0, 16'h0, lat);
    check("kbd_lat", 32'(lat), 32'd2);
    check("kbd_data", 32'(cpu_rdata), 32'h0041);
    cpu_txn(15'h6000, 1'b1, 16'h1111, lat);
    check("kbd_wr_lat", 32'(lat), 32'd2);
    check("kbd_rdata_held", 32'(cpu_rdata), 32'h0041);
    check("kbd_no_we", 32'(we_seen - w0), 32'd0);

    // 5: unmapped read/write, plus both edges of the screen window
    w0 = we_seen;
    cpu_txn(15'h7000, 1'b0, 16'h0, lat);
    check("unmap_lat", 32'(lat), 32'd2);
    check("unmap_data", 32'(cpu_rdata), 32'h0);
    cpu_txn(15'h2000, 1'b1, 16'h5555, lat);
    check("unmap_no_we", 32'(we_seen - w0), 32'd0);
    cpu_txn(15'h5FFF, 1'b0, 16'h0, lat);
    check("scr_end_lat", 32'(lat), 32'd3);
    check("scr_end_data", 32'(cpu_rdata), 32'(init_val(8191)));
    cpu_txn(15'h3FFF, 1'b0, 16'h0, lat);
    check("below_scr_lat", 32'(lat), 32'd2);

    // 4: video held continuously while the CPU competes
    vid_addr = 13'd100; vid_req = 1'b1;
    cycle();
    cpu_addr = 15'h4005; cpu_we = 1'b0; cpu_req = 1'b1; lat = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      lat++;
      if (vid_ack) vid_addr = vid_addr + 13'd1;
      if (cpu_ack) break;
    end
    check("contend_cpu_lat", 32'(lat), 32'd5);
    check("contend_cpu_rd", 32'(cpu_rdata), 32'hBEEF);
    cpu_req = 1'b0; gap = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      gap++;
      if (vid_ack) break;
    end
    check("vid_resume_gap", 32'(gap), 32'd3);
    vid_req = 1'b0;
    cycle(); cycle();

    // 6: reset pulse while a write is being issued
    cpu_addr = 15'h4010; cpu_we = 1'b1; cpu_wdata = 16'h1234; cpu_req = 1'b1;
    cycle();
    check("rst_we_before", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_we_drop", 32'(ram_we), 32'd0);
    check("rst_no_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    cycle(); cycle();
    check("rst_mem_intact", 32'(mem[16]), 32'(init_val(16)));
    rst_n = 1'b1;
    cycle();
    cpu_txn(15'h4010, 1'b0, 16'h0, lat);
    check("rst_rd_lat", 32'(lat), 32'd3);
    check("rst_rd_back", 32'(cpu_rdata), 32'(init_val(16)));

    // random mixed traffic
    for (int c = 0; c < 500; c++) begin
      cycle();
      if (cpu_ack) cpu_req = 1'b0;
      if (vid_ack) vid_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_addr = pick_cpu_addr(); cpu_we = 1'($urandom_range(0, 1));
        cpu_wdata = 16'($urandom); cpu_req = 1'b1;
      end
      if (!vid_req && $urandom_range(0, 1) == 0) begin
        vid_addr = ($urandom_range(0, 3) == 0) ? 13'd8191 : 13'($urandom_range(0, 15));
        vid_req = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) keyboard = 8'($urandom);
    end
    for (int k = 0; k < 40 && (cpu_req || vid_req); k++) begin
      cycle();
      if (cpu_ack) cpu_req = 1'b0;
      if (vid_ack) vid_req = 1'b0;
    end
    check("drain_cpu", 32'(cpu_req), 32'd0);
    check("drain_vid", 32'(vid_req), 32'd0);
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
